// File: rtl/mem_line_responder_if.sv
// Request/response bundle between a cache line-fill master and the memory responder.
// The master drives in_* request and response-ready signals; the responder drives out_*.
interface mem_line_responder_if #(
    parameter int LINE_BITS = 128
);
    logic                 in_req_valid;
    logic                 out_req_ready;
    logic                 in_req_write;
    logic [31:0]          in_req_addr;
    logic [LINE_BITS-1:0] in_req_wdata;
    logic                 out_resp_valid;
    logic                 in_resp_ready;
    logic                 out_resp_write;
    logic                 out_resp_err;
    logic [LINE_BITS-1:0] out_resp_rdata;

    modport master (
        output in_req_valid, in_req_write, in_req_addr, in_req_wdata, in_resp_ready,
        input  out_req_ready, out_resp_valid, out_resp_write, out_resp_err, out_resp_rdata
    );

    modport slave (
        input  in_req_valid, in_req_write, in_req_addr, in_req_wdata, in_resp_ready,
        output out_req_ready, out_resp_valid, out_resp_write, out_resp_err, out_resp_rdata
    );
endinterface

// File: rtl/mem_line_responder.sv
// Main-memory model answering full-line reads/writes after a fixed latency.
// Define MEM_STATS_EN to add saturating in-range read/write commit counters.
module mem_line_responder #(
    parameter int LINE_BITS   = 128,
    parameter int DEPTH_LINES = 256,
    parameter int LATENCY     = 10
) (
    input  logic        clk,
    input  logic        reset,
    mem_line_responder_if.slave bus,
`ifdef MEM_STATS_EN
    output logic [31:0] out_read_count,
    output logic [31:0] out_write_count,
`endif
    output logic        out_busy
);
    localparam int OFF   = $clog2(LINE_BITS / 8);
    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_LINES) * 33'(LINE_BITS / 8);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [LINE_BITS-1:0] mem [DEPTH_LINES];

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 write_q, write_d;
    logic                 err_q, err_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [LINE_BITS-1:0] wdata_q, wdata_d;
    logic [LINE_BITS-1:0] rdata_q, rdata_d;
    logic                 commit;
    logic                 req_oor;

    assign req_oor = ({1'b0, bus.in_req_addr} >= ADDR_LIMIT);
    assign commit  = (state_q == WAIT) && (cnt_q == CNT_LAST);

    // Errored requests are latched with err set and never reach the array.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        err_d   = err_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (bus.in_req_valid) begin
                    write_d = bus.in_req_write;
                    err_d   = req_oor;
                    idx_d   = bus.in_req_addr[OFF +: IDX_W];
                    wdata_d = bus.in_req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (commit) begin
                    rdata_d = (write_q || err_q) ? '0 : mem[idx_q];
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.in_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // The array survives reset; a reset on the commit edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!reset && commit && write_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef MEM_STATS_EN
    logic [31:0] read_cnt_q, write_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            read_cnt_q  <= '0;
            write_cnt_q <= '0;
        end else if (commit && !err_q) begin
            if (write_q && write_cnt_q != 32'hFFFF_FFFF) begin
                write_cnt_q <= write_cnt_q + 32'd1;
            end
            if (!write_q && read_cnt_q != 32'hFFFF_FFFF) begin
                read_cnt_q <= read_cnt_q + 32'd1;
            end
        end
    end

    assign out_read_count  = read_cnt_q;
    assign out_write_count = write_cnt_q;
`endif

    assign bus.out_req_ready  = (state_q == IDLE);
    assign bus.out_resp_valid = (state_q == RESP);
    assign bus.out_resp_write = write_q;
    assign bus.out_resp_err   = err_q;
    assign bus.out_resp_rdata = rdata_q;
    assign out_busy           = (state_q != IDLE);
endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder at default parameters (128-bit lines, 256 lines, latency 10).
module tb_mem_line_responder;
    localparam int LB = 128;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic out_busy;
`ifdef MEM_STATS_EN
    logic [31:0] out_read_count, out_write_count;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [LB-1:0] LINE_A  = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [LB-1:0] LINE_0  = 128'hDEADBEEF_00000001_CAFEF00D_12345678;
    localparam logic [LB-1:0] LINE_TOP = 128'h11112222_33334444_55556666_77778888;
    localparam logic [LB-1:0] LINE_AA = {16{8'hAA}};
    localparam logic [LB-1:0] LINE_55 = {16{8'h55}};

    mem_line_responder_if #(.LINE_BITS(LB)) bus ();

    mem_line_responder #(.LINE_BITS(LB), .DEPTH_LINES(256), .LATENCY(10)) dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus.slave),
`ifdef MEM_STATS_EN
        .out_read_count  (out_read_count),
        .out_write_count (out_write_count),
`endif
        .out_busy        (out_busy)
    );

    always #5 clk = ~clk;

    // Issue one request, then count edges until resp_valid (bounded; -1 on timeout).
    task automatic do_request(input logic w, input logic [31:0] a, input logic [LB-1:0] d,
                              output int lat);
        @(negedge clk);
        bus.in_req_valid = 1'b1;
        bus.in_req_write = w;
        bus.in_req_addr  = a;
        bus.in_req_wdata = d;
        @(posedge clk);
        #1;
        bus.in_req_valid = 1'b0;
        bus.in_req_wdata = '1;
        bus.in_req_addr  = 32'hFFFF_FFF0;
        lat = 0;
        while (!bus.out_resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.out_resp_valid) lat = -1;
    endtask

    task automatic finish_resp();
        @(negedge clk);
        bus.in_resp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.out_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", bus.out_req_ready); end
        checks++; if (bus.out_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", bus.out_resp_valid); end
        checks++; if (bus.out_resp_write !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_write got %b want 0", bus.out_resp_write); end
        checks++; if (bus.out_resp_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_err got %b want 0", bus.out_resp_err); end
        checks++; if (bus.out_resp_rdata !== '0) begin errors++; $display("[TB] FAIL reset_rdata got %h want 0", bus.out_resp_rdata); end
        checks++; if (out_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", out_busy); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        int lat;
        do_request(1'b1, 32'h20, LINE_A, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL wr_latency got %0d want 10", lat); end
        checks++; if (bus.out_resp_write !== 1'b1) begin errors++; $display("[TB] FAIL wr_echo got %b want 1", bus.out_resp_write); end
        checks++; if (bus.out_resp_err !== 1'b0) begin errors++; $display("[TB] FAIL wr_err got %b want 0", bus.out_resp_err); end
        checks++; if (bus.out_resp_rdata !== '0) begin errors++; $display("[TB] FAIL wr_rdata got %h want 0", bus.out_resp_rdata); end
        checks++; if (out_busy !== 1'b1) begin errors++; $display("[TB] FAIL wr_busy got %b want 1", out_busy); end
        finish_resp();
        do_request(1'b0, 32'h20, '0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL rd_latency got %0d want 10", lat); end
        checks++; if (bus.out_resp_rdata !== LINE_A) begin errors++; $display("[TB] FAIL rd_data got %h want %h", bus.out_resp_rdata, LINE_A); end
        checks++; if (bus.out_resp_write !== 1'b0) begin errors++; $display("[TB] FAIL rd_echo got %b want 0", bus.out_resp_write); end
        finish_resp();
    endtask

    task automatic test_backpressure();
        int lat;
        do_request(1'b0, 32'h20, '0, lat);
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.out_resp_valid !== 1'b1 || bus.out_resp_rdata !== LINE_A || bus.out_resp_err !== 1'b0 || bus.out_req_ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d] got valid=%b err=%b ready=%b data=%h want 1 0 0 %h", i,
                         bus.out_resp_valid, bus.out_resp_err, bus.out_req_ready, bus.out_resp_rdata, LINE_A);
            end
            @(posedge clk);
            #1;
        end
        finish_resp();
        checks++; if (bus.out_resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_valid got %b want 0", bus.out_resp_valid); end
        checks++; if (bus.out_req_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release_ready got %b want 1", bus.out_req_ready); end
        checks++; if (out_busy !== 1'b0) begin errors++; $display("[TB] FAIL bp_release_busy got %b want 0", out_busy); end
    endtask

    task automatic test_out_of_range();
        int lat;
        do_request(1'b1, 32'h0, LINE_0, lat);
        finish_resp();
        do_request(1'b1, 32'hFF0, LINE_TOP, lat);
        checks++; if (bus.out_resp_err !== 1'b0) begin errors++; $display("[TB] FAIL top_line_err got %b want 0", bus.out_resp_err); end
        finish_resp();
        do_request(1'b1, 32'h1000, LINE_55, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL oor_wr_latency got %0d want 10", lat); end
        checks++; if (bus.out_resp_err !== 1'b1) begin errors++; $display("[TB] FAIL oor_wr_err got %b want 1", bus.out_resp_err); end
        checks++; if (bus.out_resp_rdata !== '0) begin errors++; $display("[TB] FAIL oor_wr_rdata got %h want 0", bus.out_resp_rdata); end
        finish_resp();
        do_request(1'b0, 32'h1000, '0, lat);
        checks++; if (bus.out_resp_err !== 1'b1) begin errors++; $display("[TB] FAIL oor_rd_err got %b want 1", bus.out_resp_err); end
        checks++; if (bus.out_resp_rdata !== '0) begin errors++; $display("[TB] FAIL oor_rd_rdata got %h want 0", bus.out_resp_rdata); end
        finish_resp();
        do_request(1'b0, 32'h0, '0, lat);
        checks++; if (bus.out_resp_rdata !== LINE_0) begin errors++; $display("[TB] FAIL line0_intact got %h want %h", bus.out_resp_rdata, LINE_0); end
        finish_resp();
        do_request(1'b0, 32'hFF0, '0, lat);
        checks++; if (bus.out_resp_rdata !== LINE_TOP) begin errors++; $display("[TB] FAIL top_line_rd got %h want %h", bus.out_resp_rdata, LINE_TOP); end
        finish_resp();
    endtask

    task automatic test_reset_abort();
        int lat;
        do_request(1'b1, 32'h40, LINE_AA, lat);
        finish_resp();
        @(negedge clk);
        bus.in_req_valid = 1'b1;
        bus.in_req_write = 1'b1;
        bus.in_req_addr  = 32'h40;
        bus.in_req_wdata = LINE_55;
        @(posedge clk);
        #1;
        bus.in_req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.out_req_ready !== 1'b1 || bus.out_resp_valid !== 1'b0 || out_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_state got ready=%b valid=%b busy=%b want 1 0 0", bus.out_req_ready, bus.out_resp_valid, out_busy);
        end
        checks++; if (bus.out_resp_write !== 1'b0 || bus.out_resp_err !== 1'b0 || bus.out_resp_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL abort_resp got write=%b err=%b data=%h want 0 0 0", bus.out_resp_write, bus.out_resp_err, bus.out_resp_rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (out_busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle_busy got %b want 0", out_busy); end
        do_request(1'b0, 32'h40, '0, lat);
        checks++; if (bus.out_resp_rdata !== LINE_AA) begin errors++; $display("[TB] FAIL abort_no_commit got %h want %h", bus.out_resp_rdata, LINE_AA); end
        finish_resp();
    endtask

    task automatic test_unaligned();
        int lat;
        do_request(1'b0, 32'h2C, '0, lat);
        checks++; if (lat !== 10) begin errors++; $display("[TB] FAIL unaligned_latency got %0d want 10", lat); end
        checks++; if (bus.out_resp_rdata !== LINE_A) begin errors++; $display("[TB] FAIL unaligned_data got %h want %h", bus.out_resp_rdata, LINE_A); end
        finish_resp();
    endtask

`ifdef MEM_STATS_EN
    task automatic test_stats();
        int lat;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_write_count !== 32'd0 || out_read_count !== 32'd0) begin
            errors++; $display("[TB] FAIL stats_reset got w=%0d r=%0d want 0 0", out_write_count, out_read_count);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_request(1'b1, 32'h100 + 32'(i * 16), LINE_55, lat);
            finish_resp();
        end
        for (int i = 0; i < 2; i++) begin
            do_request(1'b0, 32'h100, '0, lat);
            finish_resp();
        end
        do_request(1'b0, 32'h2000, '0, lat);
        finish_resp();
        checks++; if (out_write_count !== 32'd3) begin errors++; $display("[TB] FAIL stats_writes got %0d want 3", out_write_count); end
        checks++; if (out_read_count !== 32'd2) begin errors++; $display("[TB] FAIL stats_reads got %0d want 2", out_read_count); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_write_count !== 32'd0 || out_read_count !== 32'd0) begin
            errors++; $display("[TB] FAIL stats_clear got w=%0d r=%0d want 0 0", out_write_count, out_read_count);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask
`endif

    initial begin
        bus.in_req_valid  = 1'b0;
        bus.in_req_write  = 1'b0;
        bus.in_req_addr   = '0;
        bus.in_req_wdata  = '0;
        bus.in_resp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_out_of_range();
        test_reset_abort();
        test_unaligned();
`ifdef MEM_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
